fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequencer for the instruction-fetch stage. It owns the fetch PC and runs the request/response handshake with instruction memory. It holds a returned instruction while decode is stalled, and discards in-flight fetches after a redirect. It drives fetch_ready and fetch_control into the fetch/decode pipeline register, so that register either captures a valid instruction, holds, or is flushed to a bubble.

Parameters:
PC_WIDTH, 32, width of fetch PC and redirect/predicted PC
INSTR_WIDTH, 32, instruction word width
RESET_PC, 32'h8000_0000, first fetch address after reset
CNT_WIDTH, 16, width of the saturating stall counter

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
imem_req_o  output  1  instruction memory request valid
imem_addr_o  output  PC_WIDTH  request address (= current fetch PC)
imem_gnt_i  input  1  memory accepts request this cycle (req & gnt = handshake)
imem_rvalid_i  input  1  response valid; exactly one per granted request, in order, earliest one cycle after grant
imem_rdata_i  input  INSTR_WIDTH  response instruction
pred_npc_i  input  PC_WIDTH  predicted next PC for F_PC_o (combinational from predictor)
redirect_i  input  1  mispredict/exception redirect from back end
redirect_pc_i  input  PC_WIDTH  redirect target
decode_allow_in_i  input  1  decode can accept an instruction this cycle
F_PC_o  output  PC_WIDTH  PC of the instruction presented
instr_o  output  INSTR_WIDTH  instruction presented to fetch/decode register
fetch_ready_o  output  1  instr_o/F_PC_o valid this cycle
fetch_control_o  output  1  0 = flush fetch/decode register to bubble this cycle
stall_cnt_o  output  CNT_WIDTH  cycles spent in HOLD, saturating

Behaviour:
- States: RESET, REQ, WAIT, HOLD, DROP. Registers: state, pc_q, buf_q (instruction), stall counter.
- rst=1: state<=RESET, pc_q<=RESET_PC, buf_q<=0, counter<=0.
- While rst=1 or in RESET: imem_req_o=0, fetch_ready_o=0, fetch_control_o=0, instr_o=0, stall_cnt_o=0. RESET always goes to REQ next cycle.
- imem_addr_o = F_PC_o = pc_q at all times.
- fetch_control_o = ~rst & ~redirect_i & (state!=RESET).
- fetch_ready_o is forced to 0 whenever redirect_i=1.
- REQ: imem_req_o=1.
  - gnt=1 -> WAIT.
  - Otherwise stay in REQ; request and address are held stable.
- WAIT: imem_req_o=0.
  - rvalid=1 & decode_allow_in=1: fetch_ready_o=1, instr_o=imem_rdata_i (combinational pass-through, zero added latency), pc_q<=pred_npc_i, next state REQ.
  - rvalid=1 & decode_allow_in=0: fetch_ready_o=1, buf_q<=imem_rdata_i, next state HOLD.
  - rvalid=0: stay in WAIT, fetch_ready_o=0.
- HOLD: imem_req_o=0, fetch_ready_o=1, instr_o=buf_q.
  - decode_allow_in=1: pc_q<=pred_npc_i, next state REQ.
  - Otherwise stay in HOLD; counter increments each HOLD cycle and saturates at all-ones (no wrap).
- DROP: imem_req_o=0, fetch_ready_o=0. A stale response is outstanding.
  - rvalid=1: discard the response, next state REQ.
  - Otherwise stay in DROP.
- redirect_i=1 has highest priority in any non-RESET state. pc_q<=redirect_pc_i, pred_npc_i is ignored, and the next state is:
  - REQ & gnt=1 -> DROP (request already accepted).
  - REQ & gnt=0 -> REQ. imem_req_o stays 1 this cycle; the address changes next cycle.
  - WAIT & rvalid=0 -> DROP.
  - WAIT & rvalid=1 -> REQ (response discarded).
  - HOLD -> REQ (buffered instruction discarded).
  - DROP & rvalid=1 -> REQ.
  - DROP & rvalid=0 -> DROP.
- At most one outstanding request, so no ordering ambiguity. rvalid in REQ or RESET is a protocol error and is ignored.
- Reset mid-transaction: state returns to RESET. The environment must also reset memory, so no stale response arrives.
- Throughput: one instruction per 2 cycles at minimum (REQ+grant, then WAIT+rvalid).

Test Plan:
- Reset release, gnt=1 and rvalid next cycle always, decode_allow_in=1, pred_npc=PC+4 -> addresses 0x80000000, 0x80000004, 0x80000008; fetch_ready pulses every 2nd cycle with the matching instr; fetch_control=1.
- Response arrives with decode_allow_in=0 for 3 cycles -> HOLD: fetch_ready=1, instr held equal to buffered word; stall_cnt_o=3; no imem_req; PC advances only on the cycle allow_in rises.
- Redirect to 0x80001000 in the same cycle as the grant at 0x80000004 -> fetch_control=0 that cycle; next response discarded with fetch_ready=0; next request address 0x80001000.
- Redirect while in HOLD -> buffered instruction never presented; fetch_control=0 for 1 cycle; next cycle imem_req=1 with address = redirect_pc.
- Grant withheld for 4 cycles -> imem_req stays 1 with a stable address. Redirect on cycle 2 of the 4 -> address switches next cycle and no DROP occurs.
- Hold 2^CNT_WIDTH+5 HOLD cycles -> stall_cnt_o saturates at all-ones. Assert rst mid-WAIT -> all outputs 0, then first request to RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs the imem request/response
// handshake, buffers a response while decode stalls and drops fetches after a redirect.
module fetch_ctrl #(
  parameter int unsigned            PC_WIDTH    = 32,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = 32'h8000_0000,
  parameter int unsigned            CNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst,
  output logic                   imem_req_o,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  input  logic [PC_WIDTH-1:0]    pred_npc_i,
  input  logic                   redirect_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  input  logic                   decode_allow_in_i,
  output logic [PC_WIDTH-1:0]    F_PC_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic                   fetch_ready_o,
  output logic                   fetch_control_o,
  output logic [CNT_WIDTH-1:0]   stall_cnt_o
);

  typedef enum logic [2:0] {
    S_RESET,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] buf_q, buf_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   req_c, ready_c;
  logic [INSTR_WIDTH-1:0] instr_c;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    req_c   = 1'b0;
    ready_c = 1'b0;
    instr_c = '0;
    case (state_q)
      S_RESET: state_d = S_REQ;
      S_REQ: begin
        req_c = 1'b1;
        // A grant in the redirect cycle is already accepted by memory, so its response must be dropped.
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = imem_gnt_i ? S_DROP : S_REQ;
        end else if (imem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        instr_c = imem_rdata_i;
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = imem_rvalid_i ? S_REQ : S_DROP;
        end else if (imem_rvalid_i) begin
          ready_c = 1'b1;
          if (decode_allow_in_i) begin
            pc_d    = pred_npc_i;
            state_d = S_REQ;
          end else begin
            buf_d   = imem_rdata_i;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        instr_c = buf_q;
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = S_REQ;
        end else begin
          ready_c = 1'b1;
          if (decode_allow_in_i) begin
            pc_d    = pred_npc_i;
            state_d = S_REQ;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      S_DROP: begin
        if (redirect_i) pc_d = redirect_pc_i;
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_RESET;
    endcase
  end

  assign imem_req_o      = req_c & ~rst;
  assign fetch_ready_o   = ready_c & ~rst;
  assign instr_o         = rst ? '0 : instr_c;
  assign imem_addr_o     = pc_q;
  assign F_PC_o          = pc_q;
  assign fetch_control_o = ~rst & ~redirect_i & (state_q != S_RESET);
  assign stall_cnt_o     = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a memory/decode model predicts every request,
// presentation and stall count, and each scenario adds its own targeted checks.
module tb_fetch_ctrl;

  localparam int           CNT_W = 8;
  localparam logic [31:0]  RPC   = 32'h8000_0000;

  logic             clk_i = 1'b0;
  logic             rst;
  logic             imem_req_o;
  logic [31:0]      imem_addr_o;
  logic             imem_gnt_i;
  logic             imem_rvalid_i;
  logic [31:0]      imem_rdata_i;
  logic [31:0]      pred_npc_i;
  logic             redirect_i;
  logic [31:0]      redirect_pc_i;
  logic             decode_allow_in_i;
  logic [31:0]      F_PC_o;
  logic [31:0]      instr_o;
  logic             fetch_ready_o;
  logic             fetch_control_o;
  logic [CNT_W-1:0] stall_cnt_o;

  fetch_ctrl #(.PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RPC), .CNT_WIDTH(CNT_W)) dut (
    .clk_i(clk_i), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .pred_npc_i(pred_npc_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .decode_allow_in_i(decode_allow_in_i), .F_PC_o(F_PC_o), .instr_o(instr_o),
    .fetch_ready_o(fetch_ready_o), .fetch_control_o(fetch_control_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] gnt_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // stimulus knobs
  logic        rst_k = 1'b1, gnt_k = 1'b1, redir_k = 1'b0, allow_k = 1'b1;
  logic [31:0] redir_pc_k = '0;
  int          resp_dly_k = 0;

  // reference model state
  logic        in_reset = 1'b1, pend = 1'b0, held = 1'b0;
  int          pend_dly = 0;
  logic [31:0] exp_pc = RPC;
  logic [CNT_W-1:0] exp_cnt = '0;
  int          acc_cnt = 0;
  logic [31:0] last_acc_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic step();
    logic rv, exp_req, exp_rdy, exp_ctl, grant;
    rv = pend && (pend_dly == 0) && !rst_k;
    rst               = rst_k;
    imem_gnt_i        = gnt_k;
    redirect_i        = redir_k;
    redirect_pc_i     = redir_pc_k;
    decode_allow_in_i = allow_k;
    pred_npc_i        = exp_pc + 32'd4;
    imem_rvalid_i     = rv;
    imem_rdata_i      = rv ? mem_word(exp_q.size() > 0 ? exp_q[0].pc : 32'hDEAD_0000) : $urandom;
    #2;
    exp_req = !rst_k && !in_reset && !pend && !held;
    exp_rdy = !rst_k && !redir_k && (exp_q.size() > 0) && (rv || held);
    exp_ctl = !rst_k && !redir_k && !in_reset;
    n_checks += 4;
    if (imem_req_o !== exp_req) begin
      n_fail++; $display("FAIL req t=%0t got %b want %b", $time, imem_req_o, exp_req);
    end
    if (fetch_ready_o !== exp_rdy) begin
      n_fail++; $display("FAIL ready t=%0t got %b want %b", $time, fetch_ready_o, exp_rdy);
    end
    if (fetch_control_o !== exp_ctl) begin
      n_fail++; $display("FAIL control t=%0t got %b want %b", $time, fetch_control_o, exp_ctl);
    end
    if (stall_cnt_o !== (rst_k ? '0 : exp_cnt)) begin
      n_fail++; $display("FAIL stall_cnt t=%0t got %0d want %0d", $time, stall_cnt_o, exp_cnt);
    end
    if (exp_req) begin
      n_checks++;
      if (imem_addr_o !== exp_pc) begin
        n_fail++; $display("FAIL addr t=%0t got %h want %h", $time, imem_addr_o, exp_pc);
      end
    end
    if (rst_k) begin
      n_checks++;
      if (instr_o !== '0) begin
        n_fail++; $display("FAIL instr_in_reset got %h want 0", instr_o);
      end
    end
    if (exp_rdy && allow_k) begin
      n_checks += 2;
      if (instr_o !== exp_q[0].ins) begin
        n_fail++; $display("FAIL instr t=%0t got %h want %h", $time, instr_o, exp_q[0].ins);
      end
      if (F_PC_o !== exp_q[0].pc) begin
        n_fail++; $display("FAIL fpc t=%0t got %h want %h", $time, F_PC_o, exp_q[0].pc);
      end
    end
    // advance the model to the next cycle
    if (rst_k) begin
      in_reset = 1'b1; pend = 1'b0; held = 1'b0; exp_q.delete();
      exp_pc = RPC; exp_cnt = '0;
    end else begin
      in_reset = 1'b0;
      grant = exp_req && gnt_k;
      if (rv) pend = 1'b0;
      else if (pend) pend_dly--;
      if (grant) begin
        pend = 1'b1; pend_dly = resp_dly_k; gnt_log.push_back(exp_pc);
        if (!redir_k) exp_q.push_back('{pc: exp_pc, ins: mem_word(exp_pc)});
      end
      if (redir_k) begin
        exp_q.delete(); held = 1'b0; exp_pc = redir_pc_k;
      end else if (exp_rdy) begin
        if (allow_k) begin
          last_acc_pc = exp_q[0].pc; acc_cnt++;
          void'(exp_q.pop_front()); held = 1'b0; exp_pc = exp_pc + 32'd4;
        end else begin
          if (held && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
          held = 1'b1;
        end
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_k = 1'b1;
    repeat (3) step();
    n_checks += 3;
    if (imem_req_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs req=%b ready=%b want 0", imem_req_o, fetch_ready_o);
    end
    if (fetch_control_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl got %b want 0", fetch_control_o);
    end
    if (imem_addr_o !== RPC) begin
      n_fail++; $display("FAIL reset_pc got %h want %h", imem_addr_o, RPC);
    end
  endtask

  task automatic test_fetch();
    int a0;
    rst_k = 1'b0; gnt_k = 1'b1; allow_k = 1'b1; redir_k = 1'b0; resp_dly_k = 0;
    gnt_log.delete(); a0 = acc_cnt;
    repeat (13) step();
    n_checks += 4;
    if (acc_cnt - a0 !== 6) begin
      n_fail++; $display("FAIL fetch_count got %0d want 6", acc_cnt - a0);
    end
    if (gnt_log[0] !== 32'h8000_0000) begin
      n_fail++; $display("FAIL fetch_addr0 got %h want 80000000", gnt_log[0]);
    end
    if (gnt_log[1] !== 32'h8000_0004) begin
      n_fail++; $display("FAIL fetch_addr1 got %h want 80000004", gnt_log[1]);
    end
    if (gnt_log[2] !== 32'h8000_0008) begin
      n_fail++; $display("FAIL fetch_addr2 got %h want 80000008", gnt_log[2]);
    end
  endtask

  task automatic test_hold();
    logic [31:0] pc0;
    pc0 = exp_pc;
    allow_k = 1'b0;
    step();
    step();
    repeat (3) step();
    n_checks += 4;
    if (stall_cnt_o !== 8'd3) begin
      n_fail++; $display("FAIL hold_cnt got %0d want 3", stall_cnt_o);
    end
    if (imem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL hold_req got %b want 0", imem_req_o);
    end
    if (instr_o !== mem_word(pc0) || fetch_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL hold_instr got %h/%b want %h/1", instr_o, fetch_ready_o, mem_word(pc0));
    end
    if (F_PC_o !== pc0) begin
      n_fail++; $display("FAIL hold_pc got %h want %h", F_PC_o, pc0);
    end
    allow_k = 1'b1;
    step();
    n_checks++;
    if (imem_addr_o !== pc0 + 32'd4) begin
      n_fail++; $display("FAIL hold_release_pc got %h want %h", imem_addr_o, pc0 + 32'd4);
    end
  endtask

  task automatic test_redirect_grant();
    int a0;
    rst_k = 1'b1; step();
    rst_k = 1'b0; allow_k = 1'b1; gnt_k = 1'b1;
    repeat (3) step();
    a0 = acc_cnt;
    redir_k = 1'b1; redir_pc_k = 32'h8000_1000;
    step();
    redir_k = 1'b0;
    step();
    n_checks += 2;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8000_1000) begin
      n_fail++; $display("FAIL redir_grant_addr got %b/%h want 1/80001000", imem_req_o, imem_addr_o);
    end
    if (acc_cnt !== a0) begin
      n_fail++; $display("FAIL redir_grant_drop got %0d accepts want %0d", acc_cnt, a0);
    end
  endtask

  task automatic test_redirect_hold();
    int a0;
    a0 = acc_cnt;
    allow_k = 1'b0;
    repeat (3) step();
    redir_k = 1'b1; redir_pc_k = 32'h8000_2000;
    step();
    redir_k = 1'b0; allow_k = 1'b1;
    n_checks += 2;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8000_2000) begin
      n_fail++; $display("FAIL redir_hold_addr got %b/%h want 1/80002000", imem_req_o, imem_addr_o);
    end
    repeat (2) step();
    if (acc_cnt !== a0 + 1 || last_acc_pc !== 32'h8000_2000) begin
      n_fail++; $display("FAIL redir_hold_next got %0d/%h want %0d/80002000", acc_cnt, last_acc_pc, a0 + 1);
    end
  endtask

  task automatic test_gnt_withheld();
    int a0;
    logic [31:0] pc0;
    a0 = acc_cnt; pc0 = exp_pc; gnt_k = 1'b0;
    step();
    n_checks += 4;
    if (imem_req_o !== 1'b1 || imem_addr_o !== pc0) begin
      n_fail++; $display("FAIL nognt_stable got %b/%h want 1/%h", imem_req_o, imem_addr_o, pc0);
    end
    redir_k = 1'b1; redir_pc_k = 32'h8000_3000;
    step();
    redir_k = 1'b0;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8000_3000) begin
      n_fail++; $display("FAIL nognt_redir got %b/%h want 1/80003000", imem_req_o, imem_addr_o);
    end
    repeat (2) step();
    if (imem_addr_o !== 32'h8000_3000) begin
      n_fail++; $display("FAIL nognt_hold_addr got %h want 80003000", imem_addr_o);
    end
    gnt_k = 1'b1;
    repeat (2) step();
    if (acc_cnt !== a0 + 1 || last_acc_pc !== 32'h8000_3000) begin
      n_fail++; $display("FAIL nognt_nodrop got %0d/%h want %0d/80003000", acc_cnt, last_acc_pc, a0 + 1);
    end
  endtask

  task automatic test_saturate();
    allow_k = 1'b0;
    repeat (2) step();
    repeat ((1 << CNT_W) + 5) step();
    n_checks++;
    if (stall_cnt_o !== {CNT_W{1'b1}}) begin
      n_fail++; $display("FAIL sat_cnt got %h want all-ones", stall_cnt_o);
    end
    allow_k = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_wait();
    resp_dly_k = 3; gnt_k = 1'b1;
    repeat (2) step();
    rst_k = 1'b1;
    step();
    n_checks += 2;
    if (imem_req_o !== 1'b0 || fetch_ready_o !== 1'b0 || fetch_control_o !== 1'b0 ||
        instr_o !== '0 || stall_cnt_o !== '0) begin
      n_fail++; $display("FAIL midreset_outs req=%b rdy=%b ctl=%b instr=%h cnt=%0d want all 0",
                         imem_req_o, fetch_ready_o, fetch_control_o, instr_o, stall_cnt_o);
    end
    rst_k = 1'b0; resp_dly_k = 0;
    step();
    if (imem_req_o !== 1'b1 || imem_addr_o !== RPC) begin
      n_fail++; $display("FAIL midreset_first got %b/%h want 1/%h", imem_req_o, imem_addr_o, RPC);
    end
    repeat (4) step();
  endtask

  initial begin
    rst = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    pred_npc_i = '0; redirect_i = 1'b0; redirect_pc_i = '0; decode_allow_in_i = 1'b0;
    test_reset();
    test_fetch();
    test_hold();
    test_redirect_grant();
    test_redirect_hold();
    test_gnt_withheld();
    test_saturate();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
